// File: rtl/spi_deserializer_if.sv
// Bundle for the serial input pair, the downstream FIFO write port and the
// status outputs of spi_deserializer. The slave modport is the deserializer
// side; the master modport is whatever drives the link and owns the FIFO.
interface spi_deserializer_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
);
    logic                 sclk;
    logic                 mosi;
    logic                 full;
    logic                 write_en;
    logic [DATAWIDTH-1:0] write_data;
    logic                 overflow;
    logic                 frame_err;
    logic                 busy;
    logic [CNTWIDTH-1:0]  word_count;

    modport master (
        output sclk,
        output mosi,
        output full,
        input  write_en,
        input  write_data,
        input  overflow,
        input  frame_err,
        input  busy,
        input  word_count
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  full,
        output write_en,
        output write_data,
        output overflow,
        output frame_err,
        output busy,
        output word_count
    );
endinterface

// File: rtl/spi_deserializer.sv
// SPI receive side: recovers MSB-first words from sclk/mosi (no chip select),
// frames them by bit count, pushes complete words into a FIFO, drops words
// when the FIFO is full and discards partial words after an idle timeout.
module spi_deserializer #(
    parameter int DATAWIDTH       = 32,
    parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH),
    parameter int TIMEOUT         = 64,
    parameter int CNTWIDTH        = 16
) (
    input logic               clk,
    input logic               rst,
    spi_deserializer_if.slave bus
);
    localparam int IDLEW = $clog2(TIMEOUT);
    localparam logic [BITCOUNTERWIDTH:0] LAST_BIT = (BITCOUNTERWIDTH+1)'(DATAWIDTH - 1);
    localparam logic [BITCOUNTERWIDTH:0] ONE_BIT  = (BITCOUNTERWIDTH+1)'(1);
    localparam logic [IDLEW-1:0]         TO_LAST  = IDLEW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RECV, PUSH} state_t;

    state_t state_reg, state_next;

    // Synchronizer stages; sclk has one extra stage for edge detection so
    // that mosi_s2 lines up with the cycle in which a fall is detected.
    logic sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
    logic mosi_s1_reg, mosi_s2_reg;

    logic [DATAWIDTH-1:0]     shift_reg, shift_next;
    logic [BITCOUNTERWIDTH:0] bit_cnt_reg, bit_cnt_next;
    logic [IDLEW-1:0]         idle_cnt_reg, idle_cnt_next;
    logic                     write_en_reg, write_en_next;
    logic [DATAWIDTH-1:0]     write_data_reg, write_data_next;
    logic                     overflow_reg, overflow_next;
    logic                     frame_err_reg, frame_err_next;
    logic                     busy_reg, busy_next;
    logic [CNTWIDTH-1:0]      word_count_reg, word_count_next;

    logic                     fall;
    logic                     rise;
    logic [DATAWIDTH-1:0]     shifted;

    assign fall = ~sclk_s2_reg & sclk_s3_reg;
    assign rise = sclk_s2_reg & ~sclk_s3_reg;

    // A one-bit word has nothing to keep from the previous contents.
    generate
        if (DATAWIDTH == 1) begin : g_shift_one
            assign shifted = mosi_s2_reg;
        end else begin : g_shift_wide
            assign shifted = {shift_reg[DATAWIDTH-2:0], mosi_s2_reg};
        end
    endgenerate

    // Bring sclk and mosi into the clk domain through matched delays.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_reg <= 1'b0;
            sclk_s2_reg <= 1'b0;
            sclk_s3_reg <= 1'b0;
            mosi_s1_reg <= 1'b0;
            mosi_s2_reg <= 1'b0;
        end else begin
            sclk_s1_reg <= bus.sclk;
            sclk_s2_reg <= sclk_s1_reg;
            sclk_s3_reg <= sclk_s2_reg;
            mosi_s1_reg <= bus.mosi;
            mosi_s2_reg <= mosi_s1_reg;
        end
    end

    // State register plus all registered datapath values and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            write_en_reg   <= 1'b0;
            write_data_reg <= '0;
            overflow_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            word_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            write_en_reg   <= write_en_next;
            write_data_reg <= write_data_next;
            overflow_reg   <= overflow_next;
            frame_err_reg  <= frame_err_next;
            busy_reg       <= busy_next;
            word_count_reg <= word_count_next;
        end
    end

    // Next-state logic: framing by bit count, idle timeout, push/drop decision.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        idle_cnt_next   = '0;
        write_en_next   = 1'b0;
        write_data_next = write_data_reg;
        overflow_next   = 1'b0;
        frame_err_next  = 1'b0;
        word_count_next = word_count_reg;

        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                if (fall) begin
                    shift_next   = shifted;
                    bit_cnt_next = ONE_BIT;
                    if (DATAWIDTH == 1) state_next = PUSH;
                    else                state_next = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LAST_BIT) state_next = PUSH;
                end else if (rise) begin
                    // Any edge shows the link is alive; idle_cnt restarts.
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == TO_LAST) begin
                    frame_err_next = 1'b1;
                    shift_next     = '0;
                    bit_cnt_next   = '0;
                    state_next     = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            PUSH: begin
                bit_cnt_next = '0;
                state_next   = IDLE;
                if (!bus.full) begin
                    write_en_next   = 1'b1;
                    write_data_next = shift_reg;
                    word_count_next = word_count_reg + 1'b1;
                end else begin
                    overflow_next = 1'b1;
                end
                // A fall here already belongs to the next word.
                if (fall) begin
                    shift_next   = shifted;
                    bit_cnt_next = ONE_BIT;
                    if (DATAWIDTH == 1) state_next = PUSH;
                    else                state_next = RECV;
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase

        busy_next = (state_next == RECV);
    end

    assign bus.write_en   = write_en_reg;
    assign bus.write_data = write_data_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.busy       = busy_reg;
    assign bus.word_count = word_count_reg;
endmodule

// File: tb/tb_spi_deserializer.sv
// Directed bench for spi_deserializer: reset/idle, single word with latency,
// back-to-back words, FIFO full, idle timeout and reset in mid-word.
module tb_spi_deserializer;
    logic clk;
    logic rst;

    spi_deserializer_if #(.DATAWIDTH(32), .CNTWIDTH(16)) bus ();

    spi_deserializer #(
        .DATAWIDTH(32),
        .TIMEOUT  (64),
        .CNTWIDTH (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect pushes and pulse counts, sampled on the falling edge.
    logic [31:0] push_q[$];
    int push_cyc  = 0;
    int ovf_cnt   = 0;
    int ferr_cnt  = 0;
    int clash_cnt = 0;
    int last_fall_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_en) begin
                push_q.push_back(bus.write_data);
                push_cyc = cyc;
                $display("[TB] push 0x%08h at cycle %0d", bus.write_data, cyc);
            end
            if (bus.overflow)  ovf_cnt++;
            if (bus.frame_err) ferr_cnt++;
            if (bus.write_en && (bus.overflow || bus.frame_err)) clash_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the top n bits of w, MSB first, half-period 2 clk; data changes
    // together with each sclk fall, as the serializer does.
    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sclk = 1'b1;
            wait_clk(2);
            bus.sclk = 1'b0;
            bus.mosi = w[31-i];
            last_fall_cyc = cyc;
            wait_clk(2);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        check({tag, "_present"}, 64'(push_q.size() > 0), 64'd1);
        got = '0;
        if (push_q.size() > 0) got = push_q.pop_front();
        check({tag, "_data"}, 64'(got), 64'(exp));
    endtask

    int ovf0;
    int ferr0;

    initial begin
        rst      = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.full = 1'b0;
        wait_clk(3);
        rst = 1'b0;

        // Reset / idle
        wait_clk(100);
        check("idle_write_en",   64'(bus.write_en),   64'd0);
        check("idle_overflow",   64'(bus.overflow),   64'd0);
        check("idle_frame_err",  64'(bus.frame_err),  64'd0);
        check("idle_busy",       64'(bus.busy),       64'd0);
        check("idle_word_count", 64'(bus.word_count), 64'd0);
        check("idle_write_data", 64'(bus.write_data), 64'd0);
        check("idle_ferr_seen",  64'(ferr_cnt),       64'd0);
        check("idle_no_push",    64'(push_q.size()),  64'd0);

        // Single word with latency
        send_bits(32'hA5A5_F00F, 32);
        wait_clk(6);
        expect_word("single", 32'hA5A5_F00F);
        check("single_latency", 64'(push_cyc - last_fall_cyc), 64'd4);
        check("single_count",   64'(bus.word_count), 64'd1);

        // Back-to-back with 1-clk gap
        send_bits(32'h0000_0001, 32);
        wait_clk(1);
        send_bits(32'h8000_0000, 32);
        wait_clk(1);
        send_bits(32'hFFFF_FFFF, 32);
        wait_clk(6);
        expect_word("b2b_0", 32'h0000_0001);
        expect_word("b2b_1", 32'h8000_0000);
        expect_word("b2b_2", 32'hFFFF_FFFF);
        check("b2b_count", 64'(bus.word_count), 64'd4);

        // FIFO full during PUSH
        ovf0 = ovf_cnt;
        bus.full = 1'b1;
        send_bits(32'h1234_5678, 32);
        wait_clk(6);
        bus.full = 1'b0;
        check("full_overflow",   64'(ovf_cnt - ovf0),  64'd1);
        check("full_no_push",    64'(push_q.size()),   64'd0);
        check("full_write_data", 64'(bus.write_data),  64'hFFFF_FFFF);
        check("full_count",      64'(bus.word_count),  64'd4);
        send_bits(32'h0BAD_F00D, 32);
        wait_clk(6);
        expect_word("after_full", 32'h0BAD_F00D);
        check("after_full_count", 64'(bus.word_count), 64'd5);

        // Idle timeout on a partial word
        ferr0 = ferr_cnt;
        send_bits(32'h5555_5555, 10);
        check("partial_busy", 64'(bus.busy), 64'd1);
        wait_clk(80);
        check("timeout_frame_err", 64'(ferr_cnt - ferr0), 64'd1);
        check("timeout_busy",      64'(bus.busy),         64'd0);
        check("timeout_no_push",   64'(push_q.size()),    64'd0);
        send_bits(32'hDEAD_BEEF, 32);
        wait_clk(6);
        expect_word("after_timeout", 32'hDEAD_BEEF);
        check("after_timeout_count", 64'(bus.word_count), 64'd6);

        // Reset in mid-word
        ferr0 = ferr_cnt;
        send_bits(32'h3C3C_3C3C, 17);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        check("midrst_count", 64'(bus.word_count), 64'd0);
        check("midrst_busy",  64'(bus.busy),       64'd0);
        wait_clk(5);
        send_bits(32'hCAFE_BABE, 32);
        wait_clk(6);
        expect_word("after_rst", 32'hCAFE_BABE);
        check("after_rst_count",  64'(bus.word_count),  64'd1);
        check("after_rst_no_ferr", 64'(ferr_cnt - ferr0), 64'd0);
        check("after_rst_no_extra", 64'(push_q.size()),  64'd0);

        check("pulse_clash", 64'(clash_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
